button_press_decoder: RTL

Classifies a debounced push-button level into single-cycle gesture events: press, release, short click, long press, auto-repeat and double click. It also keeps a wrapping press counter. It sits directly downstream of the button debounce stage, whose saturated "debounce done" condition drives `btn_db`. Its pulses feed the lab's mode and LED control logic.

---
 rtl/button_pkg.sv | 23 ++
 rtl/cycle_timer.sv | 34 +++
 rtl/button_press_decoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// button_pkg : shared types and defaults for button_press_decoder
// Revision   : 1.0
// ============================================================================
package button_pkg;

  localparam int unsigned TIMER_W = 32;

  // Defaults sized for a 100 MHz system clock
  localparam logic [TIMER_W-1:0] DEF_LONG_CYCLES   = 32'd50_000_000;
  localparam logic [TIMER_W-1:0] DEF_REPEAT_CYCLES = 32'd10_000_000;
  localparam logic [TIMER_W-1:0] DEF_DOUBLE_CYCLES = 32'd25_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2,
    GAP     = 2'd3
  } btn_state_t;

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// cycle_timer : clearable saturating up-counter with threshold hit flag
// Revision    : 1.0
// ============================================================================
module cycle_timer
  import button_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] threshold,
  output logic             hit
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != threshold)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == threshold);

endmodule
`default_nettype wire

// File: rtl/button_press_decoder.sv
`default_nettype none
// ============================================================================
// button_press_decoder : debounced button level -> registered gesture pulses
// Revision             : 1.0
// ============================================================================
module button_press_decoder
  import button_pkg::*;
#(
  parameter logic [31:0] LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic [31:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter logic [31:0] DOUBLE_CYCLES = DEF_DOUBLE_CYCLES,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_db,
  output logic             press_o,
  output logic             release_o,
  output logic             click_o,
  output logic             long_o,
  output logic             repeat_o,
  output logic             double_o,
  output logic [CNT_W-1:0] press_count
);

  btn_state_t         state, state_nx;
  logic               second, second_nx;
  logic [TIMER_W-1:0] threshold;
  logic               hit, timer_clear, timer_en;
  logic               press_nx, release_nx, click_nx, long_nx, repeat_nx, double_nx;

  // One timer serves every state; only its threshold changes
  always_comb begin
    threshold = '0;
    case (state)
      PRESSED: threshold = LONG_CYCLES - 32'd1;
      LONG:    threshold = REPEAT_CYCLES - 32'd1;
      GAP:     threshold = DOUBLE_CYCLES - 32'd1;
      default: threshold = '0;
    endcase
  end

  assign timer_en = (state != IDLE);

  cycle_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .enable   (timer_en),
    .threshold(threshold),
    .hit      (hit)
  );

  always_comb begin
    state_nx    = state;
    second_nx   = second;
    timer_clear = 1'b0;
    press_nx    = 1'b0;
    release_nx  = 1'b0;
    click_nx    = 1'b0;
    long_nx     = 1'b0;
    repeat_nx   = 1'b0;
    double_nx   = 1'b0;
    case (state)
      IDLE: begin
        second_nx   = 1'b0;
        timer_clear = 1'b1;
        if (btn_db) begin
          state_nx = PRESSED;
          press_nx = 1'b1;
        end
      end
      PRESSED: begin
        // Release is tested first so it beats a coincident long threshold
        if (!btn_db) begin
          release_nx  = 1'b1;
          timer_clear = 1'b1;
          if (!second) begin
            click_nx = 1'b1;
            state_nx = GAP;
          end else begin
            state_nx = IDLE;
          end
        end else if (hit) begin
          state_nx    = LONG;
          long_nx     = 1'b1;
          timer_clear = 1'b1;
        end
      end
      LONG: begin
        if (!btn_db) begin
          state_nx    = IDLE;
          release_nx  = 1'b1;
          timer_clear = 1'b1;
        end else if (hit) begin
          repeat_nx   = 1'b1;
          timer_clear = 1'b1;
        end
      end
      GAP: begin
        // Press beats a coincident window expiry
        if (btn_db) begin
          state_nx    = PRESSED;
          second_nx   = 1'b1;
          press_nx    = 1'b1;
          double_nx   = 1'b1;
          timer_clear = 1'b1;
        end else if (hit) begin
          state_nx    = IDLE;
          timer_clear = 1'b1;
        end
      end
      default: begin
        state_nx    = IDLE;
        timer_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      second      <= 1'b0;
      press_o     <= 1'b0;
      release_o   <= 1'b0;
      click_o     <= 1'b0;
      long_o      <= 1'b0;
      repeat_o    <= 1'b0;
      double_o    <= 1'b0;
      press_count <= '0;
    end else begin
      state     <= state_nx;
      second    <= second_nx;
      press_o   <= press_nx;
      release_o <= release_nx;
      click_o   <= click_nx;
      long_o    <= long_nx;
      repeat_o  <= repeat_nx;
      double_o  <= double_nx;
      if (press_nx) begin
        press_count <= press_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
